// File: rtl/an_n37_pkg.sv
// Shared constants, FSM state type and helpers for the mod-37 AN-code
// correction scheduler.
package an_n37_pkg;
  localparam int N_CELLS = 25;
  localparam int Q_W     = 13;
  localparam int R_W     = 6;
  localparam int DQ_W    = 18;
  localparam int MODULUS = 37;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORR = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [DQ_W-1:0] zext_q(input logic [Q_W-1:0] q);
    return {{(DQ_W-Q_W){1'b0}}, q};
  endfunction
endpackage

// File: rtl/an_correction_scheduler_n37_if.sv
// Frame in/out handshakes plus the side channel to the shared an_decoder_n37.
interface an_correction_scheduler_n37_if;
  import an_n37_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [N_CELLS*Q_W-1:0] in_q;
  logic [N_CELLS*R_W-1:0] in_r;
  logic [N_CELLS-1:0]     in_err;
  logic [DQ_W-1:0]        dec_quotient;
  logic [R_W-1:0]         dec_residue;
  logic [Q_W-1:0]         dec_message;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_CELLS*Q_W-1:0] out_msg;
  logic [CNT_W-1:0]       out_corr_cnt;

  modport slave (
    input  in_valid, in_q, in_r, in_err, dec_message, out_ready,
    output in_ready, dec_quotient, dec_residue, out_valid, out_msg, out_corr_cnt
  );

  modport master (
    output in_valid, in_q, in_r, in_err, dec_message, out_ready,
    input  in_ready, dec_quotient, dec_residue, out_valid, out_msg, out_corr_cnt
  );
endinterface

// File: rtl/ffs_n25.sv
// Lowest-set-bit finder over the 25-cell pending mask.
module ffs_n25 (
  input  logic [24:0] i_mask,
  output logic [4:0]  o_idx,
  output logic        o_found
);
  logic [4:0] w_idx;
  logic       w_found;

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    w_idx   = 5'd0;
    w_found = 1'b0;
    for (int i = 24; i >= 0; i--) begin
      w_idx   = i_mask[i] ? 5'(i) : w_idx;
      w_found = w_found | i_mask[i];
    end
  end

  assign o_idx   = w_idx;
  assign o_found = w_found;
endmodule

// File: rtl/an_correction_scheduler_n37.sv
// Serialises every flagged cell of a 5x5 Barrett frame through one shared
// external an_decoder_n37, lowest cell index first.
module an_correction_scheduler_n37 #(
  parameter int N_CELLS = an_n37_pkg::N_CELLS,
  parameter int Q_W     = an_n37_pkg::Q_W,
  parameter int R_W     = an_n37_pkg::R_W,
  parameter int DQ_W    = an_n37_pkg::DQ_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  an_correction_scheduler_n37_if.slave   bus
);
  import an_n37_pkg::*;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [N_CELLS-1:0]     r_pend;
  logic [N_CELLS*Q_W-1:0] r_msg;
  logic [N_CELLS*R_W-1:0] r_r;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_in_ready;
  logic                   r_out_valid;

  logic [IDX_W-1:0]       w_idx;
  logic                   w_found;
  logic [N_CELLS-1:0]     w_onehot;
  logic [N_CELLS-1:0]     w_pend_next;
  logic                   w_accept;
  logic                   w_correct;

  ffs_n25 u_ffs (
    .i_mask  (r_pend),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_onehot    = {{(N_CELLS-1){1'b0}}, 1'b1} << w_idx;
  assign w_pend_next = r_pend & ~w_onehot;

  // Next-state and per-cycle strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_correct    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_next_state = (|bus.in_err) ? ST_CORR : ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CORR: begin
        w_correct = w_found;
        if (w_pend_next == {N_CELLS{1'b0}}) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_CORR;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Decoder feed: only the currently selected cell, zero outside CORR.
  always_comb begin
    bus.dec_quotient = {DQ_W{1'b0}};
    bus.dec_residue  = {R_W{1'b0}};
    if (r_state == ST_CORR) begin
      bus.dec_quotient = zext_q(r_msg[w_idx*Q_W +: Q_W]);
      bus.dec_residue  = r_r[w_idx*R_W +: R_W];
    end else begin
      bus.dec_quotient = {DQ_W{1'b0}};
      bus.dec_residue  = {R_W{1'b0}};
    end
  end

  // Frame storage, in-place correction and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= {N_CELLS{1'b0}};
      r_msg       <= {(N_CELLS*Q_W){1'b0}};
      r_r         <= {(N_CELLS*R_W){1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == ST_IDLE);
      r_out_valid <= (w_next_state == ST_DONE);
      if (w_accept) begin
        r_msg  <= bus.in_q;
        r_r    <= bus.in_r;
        r_pend <= bus.in_err;
        r_cnt  <= {CNT_W{1'b0}};
      end else if (w_correct) begin
        r_msg[w_idx*Q_W +: Q_W] <= bus.dec_message;
        r_pend                  <= w_pend_next;
        r_cnt                   <= r_cnt + 5'd1;
      end else begin
        r_pend <= r_pend;
      end
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_msg      = r_msg;
  assign bus.out_corr_cnt = r_cnt;
endmodule

// File: doc/an_correction_scheduler_n37.md
AN_CORRECTION_SCHEDULER_N37 -- requirements
Module: an_correction_scheduler_n37

Interface
REQ-001 SHALL have parameter N_CELLS, 25, number of Barrett cells per frame (5x5).
REQ-002 SHALL have parameter Q_W, 13, Barrett quotient / message width.
REQ-003 SHALL have parameter R_W, 6, Barrett residue width (mod 37).
REQ-004 SHALL have parameter DQ_W, 18, decoder quotient input width.
REQ-005 SHALL have one clock and an asynchronous active-low reset, as follows.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous assert, synchronous deassert externally; active-low.
REQ-008 in_valid  input  1  the frame on in_q/in_r/in_err is valid.
REQ-009 in_ready  output  1  the block accepts a frame this cycle.
REQ-010 in_q  input  N_CELLS*Q_W  per-cell Barrett quotients; cell k at [k*Q_W +: Q_W].
REQ-011 in_r  input  N_CELLS*R_W  per-cell Barrett residues; cell k at [k*R_W +: R_W].
REQ-012 in_err  input  N_CELLS  per-cell error flags (residue nonzero); bit k is cell k, row k/5, col k%5.
REQ-013 dec_quotient  output  DQ_W  quotient to the shared an_decoder_n37.
REQ-014 dec_residue  output  R_W  residue to the shared an_decoder_n37.
REQ-015 dec_message  input  Q_W  corrected message from an_decoder_n37, combinational, same cycle.
REQ-016 out_valid  output  1  corrected frame is valid.
REQ-017 out_ready  input  1  downstream accepts the frame.
REQ-018 out_msg  output  N_CELLS*Q_W  corrected frame; same packing as in_q.
REQ-019 out_corr_cnt  output  5  number of cells corrected in the current frame (0..25).

Function
REQ-020 SHALL implement the FSM IDLE -> CORR -> DONE -> IDLE.
REQ-021 IDLE: in_ready=1; on in_valid, SHALL register in_q, in_r, and in_err as the pending mask, and clear out_corr_cnt; next state is CORR if in_err!=0, else DONE.
REQ-022 CORR: in_ready=0; each cycle SHALL select k = lowest set bit of the pending mask.
REQ-023 CORR: drive dec_quotient = zero-extended q[k] and dec_residue = r[k].
REQ-024 CORR: on the same clock edge, write dec_message into slot k, clear pending bit k, and increment out_corr_cnt.
REQ-025 CORR: when the cleared bit was the last pending bit, the next state SHALL be DONE.
REQ-026 Cells whose error flag is clear SHALL pass through to out_msg unmodified (registered q).
REQ-027 Unlike a single-correction priority mux, every flagged cell SHALL be corrected: up to 25 per frame, serialised over the one shared decoder.
REQ-028 Outside CORR, dec_quotient and dec_residue SHALL be 0.
REQ-029 DONE: out_valid=1; out_msg and out_corr_cnt SHALL hold stable until out_valid&&out_ready, then the FSM goes to IDLE.
REQ-030 Latency SHALL be 1+E cycles from input acceptance to out_valid, where E = popcount(in_err); E=0 gives 1 cycle.
REQ-031 in_ready and out_valid SHALL never be high in the same cycle; back-to-back throughput is one frame per 2+E cycles minimum.
REQ-032 in_valid outside IDLE SHALL be ignored; out_ready while out_valid=0 SHALL be ignored.
REQ-033 out_corr_cnt SHALL saturate-free count to 25 exactly (5-bit, no wrap is possible).

Reset
REQ-034 While rst_n=0: FSM=IDLE, pending=0, all registered q/r/msg=0, out_corr_cnt=0, out_valid=0, in_ready=0.
REQ-035 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-036 Reset asserted mid-CORR or mid-DONE SHALL discard the frame with no partial output.

Structure
REQ-037 N_CELLS, Q_W, R_W, DQ_W, the modulus 37 and the FSM state enum SHALL live in shared package an_n37_pkg.
REQ-038 Lowest-set-bit selection SHALL be a sub-module ffs_n25 (25-bit mask in; 5-bit index and found flag out).
REQ-039 an_decoder_n37 SHALL remain external; it is not instantiated in this block.

Verification
REQ-040 in_err=0, arbitrary q -> out_valid at cycle 1, out_msg=in_q, out_corr_cnt=0, dec_* stay 0.
REQ-041 in_err=bit 12, q[12]=0x0ABC, r[12]=5, decoder model -> dec_quotient=0x00ABC and dec_residue=5 at cycle 1; out slot 12 = model result; out_valid at cycle 2; cnt=1.
REQ-042 in_err bits {24,0,7} -> decoder visits cells 0,7,24 in cycles 1,2,3; out_valid at cycle 4; cnt=3.
REQ-043 in_err=0x1FFFFFF -> 25 decoder cycles in index order; out_valid at cycle 26; cnt=25.
REQ-044 out_ready low for 10 cycles in DONE -> out_msg stable, in_ready=0, in_valid ignored; acceptance occurs only in the cycle after the handoff.
REQ-045 rst_n pulsed low at the 2nd CORR cycle of a 4-error frame -> immediate IDLE with all outputs 0; the next frame is processed correctly.
